// File: rtl/mul_pkg.sv
// Shared definitions for the EX-stage multiplier: state encoding, default sizes,
// and the ALU-control code the decoder uses to mark a MUL instruction.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  localparam logic [3:0] ALU_CTRL_MUL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add_core.sv
// Unsigned shift-add datapath: operand/accumulator registers, adder, shifter and
// iteration counter. One multiplier bit is retired per step.
module mul_shift_add_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] product_o
);

  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [3*WIDTH-1:0] shifted;

  // The upper-half sum keeps its carry; shifting {sum, acc_lo, mplier} right by
  // one drops the retired multiplier bit and brings the carry into acc.
  always_comb begin
    addend  = mplier_q[0] ? mcand_q : '0;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    shifted = {sum, acc_q[WIDTH-1:0], mplier_q[WIDTH-1:1]};

    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = shifted[3*WIDTH-1:WIDTH];
      mplier_d = shifted[WIDTH-1:0];
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign last_o    = (cnt_q == CNT_W'(WIDTH - 1));
  assign product_o = acc_q;

endmodule

// File: rtl/ex_mul_unit.sv
// EX-stage multi-cycle multiplier: accepts a MUL from ID/EX, stalls the front of
// the pipeline while iterating, then presents the signed/unsigned product for one cycle.
//
// Handshake: an instruction is taken on the edge where state is IDLE, valid_i=1 and
// flush_i=0; stall_o holds IF/ID and ID/EX from that cycle through the last BUSY
// cycle, and done_o marks the single cycle in which product_o/RDaddr_o are valid.
module ex_mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   RSdata_i,
  input  logic [WIDTH-1:0]   RTdata_i,
  input  logic [4:0]         RDaddr_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic [4:0]         RDaddr_o,
  output logic [1:0]         state_o
);

  mul_state_e         state_q;
  logic               neg_q;
  logic [4:0]         rd_q;
  logic [2*WIDTH-1:0] product_q;
  logic [4:0]         rdaddr_q;

  logic               accept;
  logic               step;
  logic               last;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [2*WIDTH-1:0] core_prod;
  logic [2*WIDTH-1:0] fixed_prod;

  assign accept = (state_q == S_IDLE) && valid_i && !flush_i;
  assign step   = (state_q == S_BUSY) && !flush_i;

  // Negating the most negative value yields itself, which read as unsigned is the
  // correct magnitude, so no extra operand bit is needed.
  assign rs_mag = (signed_i && RSdata_i[WIDTH-1]) ? -RSdata_i : RSdata_i;
  assign rt_mag = (signed_i && RTdata_i[WIDTH-1]) ? -RTdata_i : RTdata_i;

  mul_shift_add_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (accept),
    .step_i    (step),
    .mcand_i   (rs_mag),
    .mplier_i  (rt_mag),
    .last_o    (last),
    .product_o (core_prod)
  );

  assign fixed_prod = neg_q ? -core_prod : core_prod;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      neg_q     <= 1'b0;
      rd_q      <= '0;
      product_q <= '0;
      rdaddr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            neg_q   <= signed_i & (RSdata_i[WIDTH-1] ^ RTdata_i[WIDTH-1]);
            rd_q    <= RDaddr_i;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush_i)   state_q <= S_IDLE;
          else if (last) state_q <= S_DONE;
        end
        S_DONE: begin
          // Keep the presented result visible until the next completion.
          product_q <= fixed_prod;
          rdaddr_q  <= rd_q;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o   = accept || (state_q == S_BUSY);
  assign done_o    = (state_q == S_DONE);
  assign product_o = done_o ? fixed_prod : product_q;
  assign RDaddr_o  = done_o ? rd_q : rdaddr_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed bench for ex_mul_unit: hand-computed products, latency, stall window,
// flush and reset aborts, and back-to-back issue.
module tb_ex_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        sgn;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [4:0]  rdaddr;
  logic        flush;
  logic        stall_o;
  logic        done_o;
  logic [63:0] product_o;
  logic [4:0]  rdaddr_o;
  logic [1:0]  state_o;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  ex_mul_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (valid),
    .signed_i  (sgn),
    .RSdata_i  (rs),
    .RTdata_i  (rt),
    .RDaddr_i  (rdaddr),
    .flush_i   (flush),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .product_o (product_o),
    .RDaddr_o  (rdaddr_o),
    .state_o   (state_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one MUL and follows it to done_o; returns at the DONE cycle with valid still high.
  task automatic run_mul(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [63:0] exp, output int done_at);
    int n;
    int stalls;
    bit got;
    n = 0; stalls = 0; got = 0; done_at = -1;
    @(negedge clk);
    valid = 1'b1; sgn = s; rs = a; rt = b; rdaddr = rd;
    while (!got && n < 100) begin
      #1;
      if (stall_o) stalls++;
      if (done_o) begin
        got = 1;
        done_at = cyc_cnt;
        check({tag, "_prod"},    product_o, exp);
        check({tag, "_rd"},      64'(rdaddr_o), 64'(rd));
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_stalls"},  64'(stalls), 64'd33);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Drops valid after a DONE cycle and confirms nothing else completes.
  task automatic expect_quiet(input string tag);
    int dones;
    dones = 0;
    @(negedge clk);
    valid = 1'b0;
    #1;
    check({tag, "_stall_after"}, 64'(stall_o), 64'd0);
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done_o) dones++;
    end
    check({tag, "_no_extra_done"}, 64'(dones), 64'd0);
  endtask

  initial begin
    int d1;
    int d2;
    rst = 1'b1; valid = 1'b0; sgn = 1'b0; rs = '0; rt = '0; rdaddr = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall",   64'(stall_o),  64'd0);
    check("rst_done",    64'(done_o),   64'd0);
    check("rst_product", product_o,     64'd0);
    check("rst_rdaddr",  64'(rdaddr_o), 64'd0);
    check("rst_state",   64'(state_o),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_mul("u7x6", 1'b0, 32'd7, 32'd6, 5'd9, 64'h0000_0000_0000_002A, d1);
    expect_quiet("u7x6");
    check("hold_prod", product_o, 64'h0000_0000_0000_002A);
    check("hold_rd",   64'(rdaddr_o), 64'd9);

    run_mul("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 5'd3, 64'hFFFF_FFFF_FFFF_FFF1, d1);
    run_mul("s_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd31, 64'h4000_0000_0000_0000, d1);
    run_mul("u_max_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 64'hFFFF_FFFE_0000_0001, d1);
    run_mul("s_7xm6", 1'b1, 32'd7, 32'hFFFF_FFFA, 5'd12, 64'hFFFF_FFFF_FFFF_FFD6, d1);
    run_mul("s_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 64'd1, d1);
    run_mul("u_zero", 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd4, 64'd0, d1);
    run_mul("s_pos", 1'b1, 32'h7FFF_FFFF, 32'd2, 5'd5, 64'h0000_0000_FFFF_FFFE, d1);
    expect_quiet("s_pos");

    // Flush during BUSY iteration 10.
    @(negedge clk);
    valid = 1'b1; sgn = 1'b0; rs = 32'd100; rt = 32'd200; rdaddr = 5'd7;
    repeat (10) @(negedge clk);
    #1;
    check("flush_busy_stall", 64'(stall_o), 64'd1);
    flush = 1'b1; valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_stall", 64'(stall_o), 64'd0);
    check("flush_state", 64'(state_o), 64'd0);
    begin
      int dones;
      dones = 0;
      repeat (40) begin
        @(negedge clk);
        #1;
        if (done_o) dones++;
      end
      check("flush_no_done", 64'(dones), 64'd0);
    end
    run_mul("after_flush", 1'b0, 32'd2, 32'd3, 5'd8, 64'd6, d1);
    expect_quiet("after_flush");

    // Reset during BUSY iteration 20.
    @(negedge clk);
    valid = 1'b1; sgn = 1'b1; rs = 32'd1000; rt = 32'hFFFF_FFF0; rdaddr = 5'd17;
    repeat (20) @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_stall",   64'(stall_o),  64'd0);
    check("midrst_done",    64'(done_o),   64'd0);
    check("midrst_product", product_o,     64'd0);
    check("midrst_rdaddr",  64'(rdaddr_o), 64'd0);
    check("midrst_state",   64'(state_o),  64'd0);

    // Back-to-back: second MUL presented in the cycle after DONE.
    run_mul("b2b_a", 1'b0, 32'd123, 32'd456, 5'd10, 64'd56088, d1);
    run_mul("b2b_b", 1'b1, 32'hFFFF_FF9C, 32'd50, 5'd11, 64'hFFFF_FFFF_FFFF_EC78, d2);
    check("b2b_spacing", 64'(d2 - d1), 64'd34);
    expect_quiet("b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
